// File: rtl/i2c_byte_sequencer.sv
// i2c_byte_sequencer: turns host byte requests into bit-controller commands.
// Serialises/deserialises bytes MSB-first and handles the 9th (ACK) bit.
module i2c_byte_sequencer (
    input  logic       clk,
    input  logic       nReset,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       read,
    input  logic       write,
    input  logic       ack_in,
    input  logic [7:0] din,
    output logic       cmd_ack,
    output logic       ack_out,
    output logic [7:0] dout,
    output logic [3:0] bit_cmd,
    input  logic       bit_cmd_ack,
    output logic       bit_din,
    input  logic       bit_dout,
    input  logic       bit_al,
    output logic       i2c_al
);

    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WRITE,
        ST_READ,
        ST_ACK,
        ST_STOP
    } state_t;

    state_t     state;
    logic [7:0] sr;
    logic [2:0] cnt;
    logic       go;
    logic       last_bit;

    // cmd_ack term blocks a retrigger while the host still holds its request
    assign go       = (read | write | stop) & ~cmd_ack;
    assign last_bit = (cnt == 3'd0);
    assign dout     = sr;

    // Byte sequencer FSM with registered bit-controller and host outputs
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state   <= ST_IDLE;
            sr      <= 8'h00;
            cnt     <= 3'd0;
            bit_cmd <= CMD_NOP;
            bit_din <= 1'b1;
            cmd_ack <= 1'b0;
            ack_out <= 1'b0;
            i2c_al  <= 1'b0;
        end else if (rst) begin
            state   <= ST_IDLE;
            sr      <= 8'h00;
            cnt     <= 3'd0;
            bit_cmd <= CMD_NOP;
            bit_din <= 1'b1;
            cmd_ack <= 1'b0;
            ack_out <= 1'b0;
            i2c_al  <= 1'b0;
        end else begin
            i2c_al  <= bit_al;
            cmd_ack <= 1'b0;
            if (bit_al) begin
                state   <= ST_IDLE;
                bit_cmd <= CMD_NOP;
                bit_din <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (go) begin
                            sr  <= din;
                            cnt <= 3'd7;
                            if (start) begin
                                state   <= ST_START;
                                bit_cmd <= CMD_START;
                                bit_din <= 1'b1;
                            end else if (read) begin
                                state   <= ST_READ;
                                bit_cmd <= CMD_READ;
                                bit_din <= 1'b1;
                            end else if (write) begin
                                state   <= ST_WRITE;
                                bit_cmd <= CMD_WRITE;
                                bit_din <= din[7];
                            end else begin
                                state   <= ST_STOP;
                                bit_cmd <= CMD_STOP;
                                bit_din <= 1'b1;
                            end
                        end
                    end
                    ST_START: begin
                        if (bit_cmd_ack) begin
                            if (read) begin
                                state   <= ST_READ;
                                bit_cmd <= CMD_READ;
                                bit_din <= 1'b1;
                            end else if (write) begin
                                state   <= ST_WRITE;
                                bit_cmd <= CMD_WRITE;
                                bit_din <= sr[7];
                            end else begin
                                state   <= ST_STOP;
                                bit_cmd <= CMD_STOP;
                                bit_din <= 1'b1;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (bit_cmd_ack) begin
                            sr  <= {sr[6:0], bit_dout};
                            cnt <= cnt - 3'd1;
                            if (last_bit) begin
                                state   <= ST_ACK;
                                bit_cmd <= CMD_READ;
                                bit_din <= 1'b1;
                            end else begin
                                bit_din <= sr[6];
                            end
                        end
                    end
                    ST_READ: begin
                        if (bit_cmd_ack) begin
                            sr  <= {sr[6:0], bit_dout};
                            cnt <= cnt - 3'd1;
                            if (last_bit) begin
                                state   <= ST_ACK;
                                bit_cmd <= CMD_WRITE;
                                bit_din <= ack_in;
                            end else begin
                                bit_din <= 1'b1;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (bit_cmd_ack) begin
                            ack_out <= bit_dout;
                            bit_din <= 1'b1;
                            if (stop) begin
                                state   <= ST_STOP;
                                bit_cmd <= CMD_STOP;
                            end else begin
                                state   <= ST_IDLE;
                                bit_cmd <= CMD_NOP;
                                cmd_ack <= 1'b1;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (bit_cmd_ack) begin
                            state   <= ST_IDLE;
                            bit_cmd <= CMD_NOP;
                            bit_din <= 1'b1;
                            cmd_ack <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        bit_cmd <= CMD_NOP;
                        bit_din <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// tb_i2c_byte_sequencer: directed and randomized requests against a
// command-list model of the byte sequencer with a bench bit controller.
module tb_i2c_byte_sequencer;

    localparam logic [3:0] NOP = 4'b0000;
    localparam logic [3:0] STA = 4'b0001;
    localparam logic [3:0] STO = 4'b0010;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] RD  = 4'b1000;

    logic       clk    = 1'b0;
    logic       nReset = 1'b1;
    logic       rst    = 1'b0;
    logic       start  = 1'b0;
    logic       stop   = 1'b0;
    logic       read   = 1'b0;
    logic       write  = 1'b0;
    logic       ack_in = 1'b0;
    logic [7:0] din    = 8'h00;
    logic       cmd_ack;
    logic       ack_out;
    logic [7:0] dout;
    logic [3:0] bit_cmd;
    logic       bit_cmd_ack = 1'b0;
    logic       bit_din;
    logic       bit_dout = 1'b0;
    logic       bit_al = 1'b0;
    logic       i2c_al;

    int   checks = 0;
    int   errors = 0;
    logic m_ack  = 1'b0;

    always #5 clk = ~clk;

    i2c_byte_sequencer dut (
        .clk         (clk),
        .nReset      (nReset),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .read        (read),
        .write       (write),
        .ack_in      (ack_in),
        .din         (din),
        .cmd_ack     (cmd_ack),
        .ack_out     (ack_out),
        .dout        (dout),
        .bit_cmd     (bit_cmd),
        .bit_cmd_ack (bit_cmd_ack),
        .bit_din     (bit_din),
        .bit_dout    (bit_dout),
        .bit_al      (bit_al),
        .i2c_al      (i2c_al)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drop_host();
        start = 1'b0;
        stop  = 1'b0;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bit_cmd"}, 32'(bit_cmd), 32'(NOP));
        chk({tag, "_bit_din"}, 32'(bit_din), 1);
        chk({tag, "_cmd_ack"}, 32'(cmd_ack), 0);
        chk({tag, "_ack_out"}, 32'(ack_out), 0);
        chk({tag, "_dout"}, 32'(dout), 0);
        chk({tag, "_i2c_al"}, 32'(i2c_al), 0);
    endtask

    // Ack n bit commands, echoing bit_din back as bit_dout
    task automatic serve(input int nacks);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < nacks && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bit_cmd_ack) begin
                bit_cmd_ack = 1'b0;
            end else if (bit_cmd != NOP) begin
                bit_cmd_ack = 1'b1;
                bit_dout    = bit_din;
                got++;
            end
        end
        @(negedge clk);
        bit_cmd_ack = 1'b0;
        chk("serve_acks", 32'(got), 32'(nacks));
    endtask

    // One host request; the model is the expected command/bit list
    task automatic do_req(input logic s, input logic p, input logic r,
                          input logic w, input logic a,
                          input logic [7:0] d, input logic [7:0] rb,
                          input logic sa, input int dly,
                          input int al_at, input logic al_ack);
        logic [3:0] ec[$];
        logic       ed[$];
        logic       eo[$];
        logic [7:0] e_dout;
        logic [7:0] e_rot;
        logic       e_ack;
        int         n;
        int         idx;
        int         k;
        int         cyc;
        logic       ack_now;
        logic       al_now;
        logic       fin;
        idx     = 0;
        k       = 0;
        cyc     = 0;
        ack_now = 1'b0;
        al_now  = 1'b0;
        fin     = 1'b0;
        e_dout  = d;
        e_ack   = m_ack;
        if (s) begin
            ec.push_back(STA); ed.push_back(1'b1); eo.push_back(1'b1);
        end
        if (r) begin
            for (int i = 7; i >= 0; i--) begin
                ec.push_back(RD); ed.push_back(1'b1); eo.push_back(rb[i]);
            end
            ec.push_back(WR); ed.push_back(a); eo.push_back(a);
            e_dout = rb;
            e_ack  = a;
        end else if (w) begin
            for (int i = 7; i >= 0; i--) begin
                ec.push_back(WR); ed.push_back(d[i]); eo.push_back(d[i]);
            end
            ec.push_back(RD); ed.push_back(1'b1); eo.push_back(sa);
            e_ack = sa;
        end
        if (p) begin
            ec.push_back(STO); ed.push_back(1'b1); eo.push_back(1'b1);
        end
        n = ec.size();
        @(negedge clk);
        start  = s;
        stop   = p;
        read   = r;
        write  = w;
        ack_in = a;
        din    = d;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (al_now) begin
                bit_al      = 1'b0;
                bit_cmd_ack = 1'b0;
                chk("al_bit_cmd", 32'(bit_cmd), 32'(NOP));
                chk("al_i2c_al", 32'(i2c_al), 1);
                chk("al_no_cmd_ack", 32'(cmd_ack), 0);
                k     = al_at - int'(s);
                e_rot = (d << k) | (d >> (8 - k));
                chk("al_dout_hold", 32'(dout), 32'(e_rot));
                chk("al_ack_out_hold", 32'(ack_out), 32'(m_ack));
                drop_host();
                @(negedge clk);
                chk("al_i2c_al_clr", 32'(i2c_al), 0);
                chk("al_stays_idle", 32'(bit_cmd), 32'(NOP));
                chk("al_no_cmd_ack2", 32'(cmd_ack), 0);
                fin = 1'b1;
            end else if (ack_now) begin
                bit_cmd_ack = 1'b0;
                ack_now     = 1'b0;
                k           = 0;
                if (idx == n) begin
                    chk("done_cmd_ack", 32'(cmd_ack), 1);
                    chk("done_nop", 32'(bit_cmd), 32'(NOP));
                    chk("done_dout", 32'(dout), 32'(e_dout));
                    chk("done_ack_out", 32'(ack_out), 32'(e_ack));
                    m_ack = e_ack;
                    @(negedge clk);
                    chk("one_pulse", 32'(cmd_ack), 0);
                    chk("no_retrigger", 32'(bit_cmd), 32'(NOP));
                    drop_host();
                    repeat (2) @(negedge clk);
                    chk("quiet_cmd", 32'(bit_cmd), 32'(NOP));
                    chk("quiet_cmd_ack", 32'(cmd_ack), 0);
                    fin = 1'b1;
                end else begin
                    chk("early_cmd_ack", 32'(cmd_ack), 0);
                end
            end else if (bit_cmd == NOP) begin
                chk($sformatf("gap_cmd%0d", idx), 32'(bit_cmd), 32'(ec[idx]));
                drop_host();
                fin = 1'b1;
            end else begin
                k++;
                if (k >= dly) begin
                    if (idx >= n) begin
                        chk("extra_cmd", 32'(bit_cmd), 32'(NOP));
                        drop_host();
                        fin = 1'b1;
                    end else begin
                        chk($sformatf("cmd%0d", idx), 32'(bit_cmd), 32'(ec[idx]));
                        chk($sformatf("din%0d", idx), 32'(bit_din), 32'(ed[idx]));
                        if (idx == al_at) begin
                            bit_al      = 1'b1;
                            bit_cmd_ack = al_ack;
                            bit_dout    = 1'b0;
                            al_now      = 1'b1;
                        end else begin
                            bit_cmd_ack = 1'b1;
                            bit_dout    = eo[idx];
                            ack_now     = 1'b1;
                        end
                        idx++;
                    end
                end
            end
        end
        if (!fin) begin
            chk("timeout", 0, 1);
            drop_host();
            bit_cmd_ack = 1'b0;
            bit_al      = 1'b0;
        end
    endtask

    initial begin
        #1 nReset = 1'b0;
        #2 chk_reset_vals("por");
        @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_por");

        bit_cmd_ack = 1'b1;
        @(negedge clk);
        bit_cmd_ack = 1'b0;
        chk("idle_ack_ignored", 32'(bit_cmd), 32'(NOP));
        chk("idle_ack_no_cmd_ack", 32'(cmd_ack), 0);

        do_req(1, 1, 0, 1, 0, 8'hA5, 8'h00, 1'b0, 4, -1, 1'b0);
        do_req(0, 0, 1, 0, 1, 8'h00, 8'h72, 1'b0, 4, -1, 1'b0);
        do_req(0, 1, 0, 0, 0, 8'h5A, 8'h00, 1'b0, 4, -1, 1'b0);

        do_req(0, 0, 0, 1, 0, 8'hFF, 8'h00, 1'b0, 2, 2, 1'b0);
        do_req(0, 0, 0, 1, 0, 8'h5A, 8'h00, 1'b1, 3, -1, 1'b0);
        do_req(1, 0, 0, 1, 0, 8'hFF, 8'h00, 1'b0, 1, 4, 1'b1);
        do_req(0, 1, 0, 1, 0, 8'hC3, 8'h00, 1'b0, 2, -1, 1'b0);

        do_req(0, 0, 0, 1, 0, 8'h96, 8'h00, 1'b0, 1, -1, 1'b0);
        do_req(0, 0, 0, 1, 0, 8'h3C, 8'h00, 1'b0, 1, -1, 1'b0);

        for (int t = 0; t < 24; t++) begin
            logic       rs, rp, rr, rw, ra, rsa;
            logic [7:0] rd_, rrb;
            int         rdly;
            rs   = 1'($urandom);
            rp   = 1'($urandom);
            rr   = 1'($urandom);
            rw   = 1'($urandom);
            ra   = 1'($urandom);
            rsa  = 1'($urandom);
            rd_  = 8'($urandom);
            rrb  = 8'($urandom);
            rdly = int'($urandom_range(1, 4));
            if (!(rr | rw | rp)) rw = 1'b1;
            do_req(rs, rp, rr, rw, ra, rd_, rrb, rsa, rdly, -1, 1'b0);
        end

        do_req(0, 0, 1, 0, 1, 8'h00, 8'hB4, 1'b0, 1, -1, 1'b0);
        @(negedge clk);
        write = 1'b1;
        din   = 8'hA5;
        serve(3);
        chk("pre_nreset_cmd", 32'(bit_cmd), 32'(WR));
        #2 nReset = 1'b0;
        #1 chk_reset_vals("async_nreset");
        drop_host();
        @(negedge clk);
        nReset = 1'b1;
        m_ack  = 1'b0;
        @(negedge clk);
        chk_reset_vals("after_nreset");

        do_req(0, 0, 1, 0, 1, 8'h00, 8'hE1, 1'b0, 1, -1, 1'b0);
        @(negedge clk);
        write = 1'b1;
        din   = 8'hA5;
        serve(3);
        chk("pre_rst_cmd", 32'(bit_cmd), 32'(WR));
        rst    = 1'b1;
        bit_al = 1'b1;
        #1 chk("rst_sync_hold", 32'(bit_cmd), 32'(WR));
        @(negedge clk);
        chk_reset_vals("sync_rst");
        rst    = 1'b0;
        bit_al = 1'b0;
        drop_host();
        m_ack  = 1'b0;
        @(negedge clk);
        chk_reset_vals("after_rst");

        do_req(1, 1, 0, 1, 0, 8'h81, 8'h00, 1'b1, 2, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
